// File: rtl/decode_queue.sv
// RV32I decode queue: buffers fetched {pc, instruction} words in a circular FIFO
// and presents the head entry fully decoded to the issue stage.
module decode_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int PTR_W       = 2,
    parameter int PC_WIDTH    = 32
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_ins,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [5:0]          out_opcode,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [31:0]         out_imm,
    output logic                out_use_rs1,
    output logic                out_use_rs2,
    output logic                out_illegal,
    output logic [PTR_W:0]      out_count
);

    localparam logic [5:0] OP_NONE  = 6'd0;
    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd11;
    localparam logic [5:0] OP_LH    = 6'd12;
    localparam logic [5:0] OP_LW    = 6'd13;
    localparam logic [5:0] OP_LBU   = 6'd14;
    localparam logic [5:0] OP_LHU   = 6'd15;
    localparam logic [5:0] OP_SB    = 6'd16;
    localparam logic [5:0] OP_SH    = 6'd17;
    localparam logic [5:0] OP_SW    = 6'd18;
    localparam logic [5:0] OP_ADDI  = 6'd19;
    localparam logic [5:0] OP_SLTI  = 6'd20;
    localparam logic [5:0] OP_SLTIU = 6'd21;
    localparam logic [5:0] OP_XORI  = 6'd22;
    localparam logic [5:0] OP_ORI   = 6'd23;
    localparam logic [5:0] OP_ANDI  = 6'd24;
    localparam logic [5:0] OP_SLLI  = 6'd25;
    localparam logic [5:0] OP_SRLI  = 6'd26;
    localparam logic [5:0] OP_SRAI  = 6'd27;
    localparam logic [5:0] OP_ADD   = 6'd28;
    localparam logic [5:0] OP_SUB   = 6'd29;
    localparam logic [5:0] OP_SLL   = 6'd30;
    localparam logic [5:0] OP_SLT   = 6'd31;
    localparam logic [5:0] OP_SLTU  = 6'd32;
    localparam logic [5:0] OP_XOR   = 6'd33;
    localparam logic [5:0] OP_SRL   = 6'd34;
    localparam logic [5:0] OP_SRA   = 6'd35;
    localparam logic [5:0] OP_OR    = 6'd36;
    localparam logic [5:0] OP_AND   = 6'd37;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QUEUE_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [31:0]         ins_mem [QUEUE_DEPTH];
    logic [PC_WIDTH-1:0] pc_mem  [QUEUE_DEPTH];
    logic [PTR_W:0]      wptr;
    logic [PTR_W:0]      rptr;
    logic [PTR_W:0]      count;
    logic                push;
    logic                pop;

    // Handshake: a word transfers on a rising edge where valid & ready are both
    // high; valid never waits on ready, and in_ready ignores out_ready (no bypass).
    assign count     = wptr - rptr;
    assign in_ready  = rst_n_in & rdy_in & (count < DEPTH_C);
    assign out_valid = rst_n_in & rdy_in & (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wptr <= '0;
            rptr <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (push) wptr <= wptr + PTR_ONE;
                if (pop)  rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk_in) begin
        if (push && !flush_in) begin
            ins_mem[wptr[PTR_W-1:0]] <= in_ins;
            pc_mem[wptr[PTR_W-1:0]]  <= in_pc;
        end
    end

    logic [31:0]         h_ins;
    logic [PC_WIDTH-1:0] h_pc;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [5:0]          d_op;
    logic [31:0]         d_imm;
    logic                use_rd;
    logic                use_r1;
    logic                use_r2;

    assign h_ins = ins_mem[rptr[PTR_W-1:0]];
    assign h_pc  = pc_mem[rptr[PTR_W-1:0]];
    assign f3    = h_ins[14:12];
    assign f7    = h_ins[31:25];

    always_comb begin
        d_op   = OP_NONE;
        d_imm  = '0;
        use_rd = 1'b0;
        use_r1 = 1'b0;
        use_r2 = 1'b0;
        case (h_ins[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d_op   = (h_ins[6:0] == OPC_LUI) ? OP_LUI : OP_AUIPC;
                d_imm  = {h_ins[31:12], 12'b0};
                use_rd = 1'b1;
            end
            OPC_JAL: begin
                d_op   = OP_JAL;
                d_imm  = {{11{h_ins[31]}}, h_ins[31], h_ins[19:12], h_ins[20], h_ins[30:21], 1'b0};
                use_rd = 1'b1;
            end
            OPC_JALR: begin
                if (f3 == 3'b000) d_op = OP_JALR;
                d_imm  = {{20{h_ins[31]}}, h_ins[31:20]};
                use_rd = 1'b1;
                use_r1 = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  d_op = OP_BEQ;
                    3'b001:  d_op = OP_BNE;
                    3'b100:  d_op = OP_BLT;
                    3'b101:  d_op = OP_BGE;
                    3'b110:  d_op = OP_BLTU;
                    3'b111:  d_op = OP_BGEU;
                    default: d_op = OP_NONE;
                endcase
                d_imm  = {{19{h_ins[31]}}, h_ins[31], h_ins[7], h_ins[30:25], h_ins[11:8], 1'b0};
                use_r1 = 1'b1;
                use_r2 = 1'b1;
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  d_op = OP_LB;
                    3'b001:  d_op = OP_LH;
                    3'b010:  d_op = OP_LW;
                    3'b100:  d_op = OP_LBU;
                    3'b101:  d_op = OP_LHU;
                    default: d_op = OP_NONE;
                endcase
                d_imm  = {{20{h_ins[31]}}, h_ins[31:20]};
                use_rd = 1'b1;
                use_r1 = 1'b1;
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  d_op = OP_SB;
                    3'b001:  d_op = OP_SH;
                    3'b010:  d_op = OP_SW;
                    default: d_op = OP_NONE;
                endcase
                d_imm  = {{20{h_ins[31]}}, h_ins[31:25], h_ins[11:7]};
                use_r1 = 1'b1;
                use_r2 = 1'b1;
            end
            OPC_OPIMM: begin
                d_imm  = {{20{h_ins[31]}}, h_ins[31:20]};
                use_rd = 1'b1;
                use_r1 = 1'b1;
                case (f3)
                    3'b000: d_op = OP_ADDI;
                    3'b010: d_op = OP_SLTI;
                    3'b011: d_op = OP_SLTIU;
                    3'b100: d_op = OP_XORI;
                    3'b110: d_op = OP_ORI;
                    3'b111: d_op = OP_ANDI;
                    3'b001: begin
                        d_op  = (f7 == F7_ZERO) ? OP_SLLI : OP_NONE;
                        d_imm = {27'b0, h_ins[24:20]};
                    end
                    default: begin
                        if (f7 == F7_ZERO)     d_op = OP_SRLI;
                        else if (f7 == F7_ALT) d_op = OP_SRAI;
                        d_imm = {27'b0, h_ins[24:20]};
                    end
                endcase
            end
            OPC_OP: begin
                use_rd = 1'b1;
                use_r1 = 1'b1;
                use_r2 = 1'b1;
                if (f7 == F7_ZERO) begin
                    case (f3)
                        3'b000:  d_op = OP_ADD;
                        3'b001:  d_op = OP_SLL;
                        3'b010:  d_op = OP_SLT;
                        3'b011:  d_op = OP_SLTU;
                        3'b100:  d_op = OP_XOR;
                        3'b101:  d_op = OP_SRL;
                        3'b110:  d_op = OP_OR;
                        default: d_op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    d_op = OP_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    d_op = OP_SRA;
                end
            end
            default: d_op = OP_NONE;
        endcase
        // An illegal word presents nothing but its pc and the illegal flag.
        if (d_op == OP_NONE) begin
            d_imm  = '0;
            use_rd = 1'b0;
            use_r1 = 1'b0;
            use_r2 = 1'b0;
        end
    end

    assign out_pc      = rst_n_in ? h_pc : '0;
    assign out_opcode  = rst_n_in ? d_op : OP_NONE;
    assign out_imm     = rst_n_in ? d_imm : '0;
    assign out_rd      = (rst_n_in && use_rd) ? h_ins[11:7] : 5'd0;
    assign out_rs1     = (rst_n_in && use_r1) ? h_ins[19:15] : 5'd0;
    assign out_rs2     = (rst_n_in && use_r2) ? h_ins[24:20] : 5'd0;
    assign out_use_rs1 = rst_n_in & use_r1;
    assign out_use_rs2 = rst_n_in & use_r2;
    assign out_illegal = rst_n_in & (d_op == OP_NONE);
    assign out_count   = rst_n_in ? count : '0;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: a queue-based reference model checked on every cycle,
// plus directed vectors with hand-computed decode results.
module tb_decode_queue;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        flush_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic        out_use_rs1;
    logic        out_use_rs2;
    logic        out_illegal;
    logic [2:0]  out_count;

    decode_queue #(.QUEUE_DEPTH(4), .PTR_W(2), .PC_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_use_rs1(out_use_rs1), .out_use_rs2(out_use_rs2),
        .out_illegal(out_illegal), .out_count(out_count)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode numbering per mnemonic, indexed by funct3; 0 marks an unused slot.
    int br_tab[8] = '{5, 6, 0, 0, 7, 8, 9, 10};
    int ld_tab[8] = '{11, 12, 13, 0, 14, 15, 0, 0};
    int st_tab[8] = '{16, 17, 18, 0, 0, 0, 0, 0};
    int oi_tab[8] = '{19, 0, 20, 21, 22, 0, 23, 24};
    int op_tab[8] = '{28, 30, 31, 32, 33, 34, 36, 37};

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        u1;
        logic        u2;
    } dec_t;

    function automatic dec_t model_decode(input logic [31:0] ins);
        dec_t              d;
        int                code;
        byte               fmt;
        logic [2:0]        f3;
        logic [6:0]        f7;
        logic signed [20:0] j21;
        logic signed [12:0] b13;
        logic signed [11:0] s12;
        d    = '0;
        code = 0;
        fmt  = "N";
        f3   = ins[14:12];
        f7   = ins[31:25];
        case (ins[6:0])
            7'h37: begin code = 1; fmt = "U"; end
            7'h17: begin code = 2; fmt = "U"; end
            7'h6f: begin code = 3; fmt = "J"; end
            7'h67: begin code = (f3 == 0) ? 4 : 0; fmt = "I"; end
            7'h63: begin code = br_tab[f3]; fmt = "B"; end
            7'h03: begin code = ld_tab[f3]; fmt = "I"; end
            7'h23: begin code = st_tab[f3]; fmt = "S"; end
            7'h13: begin
                if (f3 == 1) begin
                    code = (f7 == 0) ? 25 : 0; fmt = "H";
                end else if (f3 == 5) begin
                    code = (f7 == 0) ? 26 : (f7 == 7'h20) ? 27 : 0; fmt = "H";
                end else begin
                    code = oi_tab[f3]; fmt = "I";
                end
            end
            7'h33: begin
                fmt = "R";
                if (f7 == 0) code = op_tab[f3];
                else if (f7 == 7'h20 && f3 == 0) code = 29;
                else if (f7 == 7'h20 && f3 == 5) code = 35;
            end
            default: code = 0;
        endcase
        if (code == 0) return d;
        d.op = 6'(code);
        case (fmt)
            "U": begin d.rd = ins[11:7]; d.imm = ins & 32'hFFFFF000; end
            "J": begin
                d.rd  = ins[11:7];
                j21   = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                d.imm = 32'(j21);
            end
            "I": begin
                d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.u1 = 1'b1;
                s12  = ins[31:20];
                d.imm = 32'(s12);
            end
            "H": begin
                d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.u1 = 1'b1;
                d.imm = 32'(ins[24:20]);
            end
            "B": begin
                d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.u1 = 1'b1; d.u2 = 1'b1;
                b13   = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                d.imm = 32'(b13);
            end
            "S": begin
                d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.u1 = 1'b1; d.u2 = 1'b1;
                s12   = {ins[31:25], ins[11:7]};
                d.imm = 32'(s12);
            end
            default: begin
                d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
                d.u1 = 1'b1; d.u2 = 1'b1;
            end
        endcase
        return d;
    endfunction

    // Reference model: queue of {pc, ins} updated on each rising edge.
    logic [63:0] exp_q[$];
    bit          m_pushed;

    always @(posedge clk_in) begin
        m_pushed = 1'b0;
        if (!rst_n_in) begin
            exp_q.delete();
        end else if (rdy_in) begin
            if (flush_in) begin
                exp_q.delete();
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = out_ready && exp_q.size() > 0;
                do_push = in_valid && exp_q.size() < DEPTH;
                if (do_pop) void'(exp_q.pop_front());
                if (do_push) begin
                    exp_q.push_back({in_pc, in_ins});
                    m_pushed = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_count", out_count, 0);
            check("rst_fields", {out_pc, out_opcode, out_rd, out_rs1, out_rs2}, 0);
            check("rst_imm_flags", {out_imm, out_use_rs1, out_use_rs2, out_illegal}, 0);
        end else begin
            check("in_ready", in_ready, rdy_in && exp_q.size() < DEPTH);
            check("out_valid", out_valid, rdy_in && exp_q.size() > 0);
            check("out_count", out_count, exp_q.size());
            if (exp_q.size() > 0) begin
                dec_t e;
                e = model_decode(exp_q[0][31:0]);
                check("out_pc", out_pc, exp_q[0][63:32]);
                check("out_opcode", out_opcode, e.op);
                check("out_rd", out_rd, e.rd);
                check("out_rs1", out_rs1, e.rs1);
                check("out_rs2", out_rs2, e.rs2);
                check("out_imm", out_imm, e.imm);
                check("out_use", {out_use_rs1, out_use_rs2}, {e.u1, e.u2});
                check("out_illegal", out_illegal, e.op == 0);
            end
        end
    end

    logic [31:0] popped_q[$];
    bit          rec_en = 1'b0;

    always @(negedge clk_in) begin
        if (rec_en && rst_n_in && rdy_in && out_valid && out_ready)
            popped_q.push_back(out_pc);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk_in);
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1;
        in_pc    = pc;
        in_ins   = ins;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [31:0] extra_vec[8] = '{32'h00C000EF, 32'h000080E7, 32'h40209093, 32'h0000B083,
                                  32'h00414083, 32'hFFF0F093, 32'h0020F463, 32'h00002063};
    int idx;

    initial begin
        rst_n_in  = 1'b0;
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        in_valid  = 1'b0;
        in_ins    = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        at_sample();
        check("lit_rst_in_ready", in_ready, 0);
        check("lit_rst_out_valid", out_valid, 0);
        tick();
        rst_n_in = 1'b1;
        at_sample();
        check("lit_release_in_ready", in_ready, 1);

        // addi x1,x0,5
        tick();
        push_one(32'h0, 32'h00500093);
        at_sample();
        check("lit_addi_valid", out_valid, 1);
        check("lit_addi_op", out_opcode, 19);
        check("lit_addi_regs", {out_rd, out_rs1}, {5'd1, 5'd0});
        check("lit_addi_imm", out_imm, 5);
        check("lit_addi_use", {out_use_rs1, out_use_rs2}, 2'b10);
        check("lit_addi_count", out_count, 1);
        pop_one();

        // Fill to full, then stream 10 words through with wrap-around.
        rec_en = 1'b1;
        popped_q.delete();
        idx = 0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
            in_pc  = 32'(idx * 4);
            in_ins = {12'(idx), 5'd0, 3'b000, 5'(idx + 1), 7'h13};
            if (idx == 4 && !out_ready) begin
                at_sample();
                check("lit_full_in_ready", in_ready, 0);
                check("lit_full_count", out_count, 4);
                out_ready = 1'b1;
            end
            tick();
            if (m_pushed) idx++;
        end
        check("stream_all_pushed", idx, 10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) tick();
        out_ready = 1'b0;
        rec_en    = 1'b0;
        check("stream_pop_count", popped_q.size(), 10);
        for (int i = 0; i < popped_q.size() && i < 10; i++)
            check("stream_pc_order", popped_q[i], 32'(i * 4));

        // sw x1,4(x2)
        push_one(32'h100, 32'h00112223);
        at_sample();
        check("lit_sw_op", out_opcode, 18);
        check("lit_sw_regs", {out_rs1, out_rs2, out_rd}, {5'd2, 5'd1, 5'd0});
        check("lit_sw_imm", out_imm, 4);
        pop_one();
        // beq x0,x0,-4
        push_one(32'h104, 32'hFE000EE3);
        at_sample();
        check("lit_beq_op", out_opcode, 5);
        check("lit_beq_imm", out_imm, 32'hFFFFFFFC);
        pop_one();
        // sub x0,x1,x2
        push_one(32'h108, 32'h40208033);
        at_sample();
        check("lit_sub_op", out_opcode, 29);
        check("lit_sub_regs", {out_rs1, out_rs2}, {5'd1, 5'd2});
        pop_one();
        push_one(32'h10C, 32'h20208033);
        at_sample();
        check("lit_badf7_illegal", out_illegal, 1);
        check("lit_badf7_zero", {out_opcode, out_rd, out_imm}, 0);
        check("lit_badf7_pc", out_pc, 32'h10C);
        pop_one();
        push_one(32'h110, 32'hFFFFFFFF);
        at_sample();
        check("lit_ones_illegal", out_illegal, 1);
        pop_one();
        // srai x1,x1,3
        push_one(32'h114, 32'h4030D093);
        at_sample();
        check("lit_srai_op", out_opcode, 27);
        check("lit_srai_imm", out_imm, 3);
        pop_one();
        // lui x1,0x12345
        push_one(32'h118, 32'h123450B7);
        at_sample();
        check("lit_lui_op", out_opcode, 1);
        check("lit_lui_imm", out_imm, 32'h12345000);
        check("lit_lui_use", {out_use_rs1, out_use_rs2, out_rs1}, 0);
        pop_one();
        for (int i = 0; i < 8; i++) begin
            push_one(32'h200 + 32'(i * 4), extra_vec[i]);
            pop_one();
        end

        // Flush with a simultaneous push and pop.
        for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(i * 4), 32'h00000013);
        at_sample();
        check("lit_preflush_count", out_count, 3);
        in_valid  = 1'b1;
        in_pc     = 32'h30C;
        in_ins    = 32'h00100093;
        out_ready = 1'b1;
        flush_in  = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_in  = 1'b0;
        at_sample();
        check("lit_flush_count", out_count, 0);
        check("lit_flush_valid", out_valid, 0);
        tick();
        at_sample();
        check("lit_flush_no_store", out_count, 0);

        // Global-ready freeze.
        push_one(32'h400, 32'h00112223);
        push_one(32'h404, 32'h00500093);
        rdy_in    = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h408;
        in_ins    = 32'h00000013;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_sample();
            check("lit_frz_ready_valid", {in_ready, out_valid}, 2'b00);
            check("lit_frz_count", out_count, 2);
            check("lit_frz_head", {out_pc, out_opcode}, {32'h400, 6'd18});
            tick();
        end
        rdy_in    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        at_sample();
        check("lit_thaw_head", {out_valid, out_pc, out_count}, {1'b1, 32'h400, 3'd2});

        // Reset mid-stream.
        rst_n_in = 1'b0;
        tick();
        at_sample();
        check("lit_midrst_in_ready", in_ready, 0);
        rst_n_in = 1'b1;
        tick();
        at_sample();
        check("lit_after_rst", {out_count, out_valid, in_ready}, {3'd0, 1'b0, 1'b1});
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Buffered, parametrised RV32I decode stage between instruction fetch and issue/dispatch.
- Accepts {pc, instruction} words over a valid/ready handshake into a QUEUE_DEPTH-entry circular FIFO.
- Presents the head entry fully decoded (rs1/rs2/rd/opcode/imm/pc) to the issue side over a second valid/ready handshake.
- Adds strict illegal-instruction detection (funct3/funct7 checking), per-register-use flags, a pipeline flush and a global-ready freeze.

Parameters:
- QUEUE_DEPTH, 4, number of FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(QUEUE_DEPTH); pointer width, with one extra bit internally for full/empty.
- PC_WIDTH, 32, width of the carried program counter.

Ports:
- clk_in  input  1  clock; all state changes on its rising edge.
- rst_n_in  input  1  synchronous active-low reset.
- rdy_in  input  1  global ready; low freezes all state.
- flush_in  input  1  discard all queued entries (branch mispredict / exception).
- in_valid  input  1  fetch offers a word.
- in_ready  output  1  queue can accept a word this cycle.
- in_ins  input  32  raw instruction.
- in_pc  input  PC_WIDTH  instruction address.
- out_valid  output  1  head entry presented.
- out_ready  input  1  issue consumes head this cycle.
- out_pc  output  PC_WIDTH  pc of head.
- out_opcode  output  6  team OP_* code from macros.v; 0 when illegal.
- out_rs1  output  5  source 1; 0 when unused.
- out_rs2  output  5  source 2; 0 when unused.
- out_rd  output  5  destination; 0 when unused.
- out_imm  output  32  sign-/zero-extended immediate; 0 when none.
- out_use_rs1  output  1  instruction reads rs1.
- out_use_rs2  output  1  instruction reads rs2.
- out_illegal  output  1  head word is not a legal RV32I instruction.
- out_count  output  PTR_W+1  entries currently held.

Behaviour:
- Reset (rst_n_in=0 at edge):
  - Pointers and count cleared.
  - While reset is asserted: in_ready=0, out_valid=0, all out_* fields 0.
  - First cycle after release: in_ready=1.
- Handshake:
  - Push occurs when in_valid & in_ready; pop occurs when out_valid & out_ready.
  - in_ready = rdy_in & (count < QUEUE_DEPTH). It does not depend on out_ready; no bypass when full.
  - out_valid = rdy_in & (count != 0).
  - Once out_valid is high, the head fields are stable until popped or flushed.
- Latency:
  - A word pushed at edge N is visible on out_* after edge N; minimum 1 cycle.
  - Decode is combinational from stored raw {pc, ins} at the read pointer.
- Simultaneous push and pop: count unchanged, both pointers advance. Pop on the last entry plus push yields count 1 and the new entry at the head.
- Wrap-around: pointers increment modulo QUEUE_DEPTH. Full/empty is distinguished by the extra MSB.
- flush_in: when high at an edge (and rdy_in=1), pointers and count are zeroed; any same-cycle push or pop is ignored. Flush has priority over push and pop.
- rdy_in=0: no push, pop or flush takes effect; storage and pointers hold.
- Decode rules (opcode field ins[6:0], funct3 ins[14:12], funct7 ins[31:25]):
  - LUI/AUIPC: imm = {ins[31:12], 12'b0}; uses rd only.
  - JAL: imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 0}); uses rd.
  - JALR: funct3 must be 000; imm = sext(ins[31:20]); uses rd, rs1.
  - BRANCH: funct3 ∈ {000,001,100,101,110,111}; imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 0}); uses rs1, rs2; rd=0.
  - LOAD: funct3 ∈ {000,001,010,100,101}; I-imm; uses rd, rs1.
  - STORE: funct3 ∈ {000,001,010}, selecting SB/SH/SW; imm = sext({ins[31:25], ins[11:7]}); uses rs1, rs2; rd=0.
  - OP-IMM: funct3 selects ADDI/SLTI/SLTIU/XORI/ORI/ANDI with I-imm.
    - SLLI requires funct7=0000000.
    - funct3=101 requires funct7 ∈ {0000000 (SRLI), 0100000 (SRAI)}.
    - Shift imm = zero-extended ins[24:20].
  - OP: funct7 must be 0000000, or 0100000 only for funct3 000 (SUB) / 101 (SRA); uses rd, rs1, rs2; imm=0.
  - Any other major opcode, funct3 or funct7 combination sets out_illegal=1, with opcode, rd, rs1, rs2 and imm all 0 and both use flags 0; out_pc is still valid.
  - All decode outputs are fully assigned in every path; no latches.

Test Plan:
- Reset, then push 0x00500093 (addi x1,x0,5) at pc 0x0 with out_ready=0 -> next cycle out_valid=1, opcode=OP_ADDI, rd=1, rs1=0, imm=5, use_rs1=1, use_rs2=0, count=1.
- Push 4 words with out_ready=0 (QUEUE_DEPTH=4) -> in_ready=0 at count 4. Then hold in_valid=1 and out_ready=1 -> pops in order, count stays ≤4, and pointers wrap over 10 consecutive words with pcs 0x0,0x4,…,0x24 emerging in order.
- Push 0x00112223 (sw x1,4(x2)) -> opcode=OP_SW, rs1=2, rs2=1, rd=0, imm=4. Push 0xFE000EE3 (beq x0,x0,-4) -> opcode=OP_BEQ, imm=0xFFFFFFFC.
- Push 0x40208033 (sub) -> OP_SUB. Push 0x20208033 (bad funct7) -> out_illegal=1, opcode=0, rd=0. Push 0xFFFFFFFF -> illegal.
- Three entries queued, flush_in=1 with in_valid=1 and out_ready=1 the same cycle -> next cycle count=0, out_valid=0, the pushed word is not stored.
- rdy_in=0 for 3 cycles with in_valid=1 and out_ready=1 -> count, head pc and fields unchanged, in_ready=0, out_valid=0; after rdy_in returns to 1, the original head is presented. Assert rst_n_in=0 mid-stream -> queue empty after one edge.
